// File: rtl/led_bank_pkg.sv
// Shared constants for the multi-bank LED controller: register offsets,
// bank width and the DUTY reset value.
package led_bank_pkg;

  localparam int BANK_W        = 8;
  localparam int REGS_PER_BANK = 2;
  localparam int OFF_DATA      = 0;
  localparam int OFF_MODE      = 1;

  localparam logic [7:0] DUTY_RST = 8'hFF;

  // Offset of a bank register from BASE_ADDR.
  function automatic logic [7:0] reg_off(input int bank, input int sel);
    return 8'(REGS_PER_BANK * bank + sel);
  endfunction

  // DUTY sits directly after the last bank's MODE register.
  function automatic logic [7:0] duty_off(input int nb);
    return 8'(REGS_PER_BANK * nb);
  endfunction

endpackage

// File: rtl/led_bank_if.sv
// Processor bus address/strobe group. The data lines are a shared tristate
// net and stay a plain inout on the peripheral.
interface led_bank_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  modport master (output BUS_ADDR, BUS_WE);
  modport slave  (input  BUS_ADDR, BUS_WE);
endinterface

// File: rtl/led_blink_timer.sv
// Free-running blink prescaler/phase and, with LED_PWM_EN, the global PWM
// counter and dimming gate.
module led_blink_timer
  import led_bank_pkg::*;
#(
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BANK_W-1:0] duty,
  output logic              phase,
  output logic              pwm_on
);

  localparam int PW = $clog2(BLINK_DIV);

  logic [PW-1:0] pre_q;
  logic          wrap;

  assign wrap = (pre_q == PW'(BLINK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      pre_q <= '0;
      phase <= ~phase;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm_q;

  always_ff @(posedge CLK) begin
    if (RESET) pwm_q <= '0;
    else       pwm_q <= pwm_q + 8'd1;
  end

  // Full-scale duty must be solid on, not 255/256.
  assign pwm_on = (pwm_q < duty) || (duty == DUTY_RST);
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign pwm_on      = 1'b1;
`endif

endmodule

// File: rtl/led_bank_ctrl.sv
// Bus-mapped multi-bank LED controller with per-LED blink and read-back.
// Define LED_PWM_EN to add the DUTY register and global PWM dimming.
module led_bank_ctrl
  import led_bank_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hC0,
  parameter int         NUM_BANKS = 2,
  parameter int         BLINK_DIV = 50_000_000
) (
  input  logic                        CLK,
  input  logic                        RESET,
  led_bank_if.slave                   bus,
  inout  wire  [7:0]                  BUS_DATA,
  output logic [BANK_W*NUM_BANKS-1:0] LED_OUT
);

  logic [NUM_BANKS-1:0][BANK_W-1:0] data_q, mode_q, led_nxt;
  logic [8:0]        off9;
  logic [7:0]        off;
  logic              reg_hit;
  logic [7:0]        rd_mux, rd_q;
  logic              drv_en;
  logic [BANK_W-1:0] duty;
  logic              phase, pwm_on;

  // Borrow bit set means the address is below BASE_ADDR.
  assign off9 = {1'b0, bus.BUS_ADDR} - {1'b0, BASE_ADDR};
  assign off  = off9[7:0];

  always_comb begin
    reg_hit = 1'b0;
    rd_mux  = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (off == reg_off(k, OFF_DATA)) begin
        reg_hit = 1'b1;
        rd_mux  = data_q[k];
      end
      if (off == reg_off(k, OFF_MODE)) begin
        reg_hit = 1'b1;
        rd_mux  = mode_q[k];
      end
    end
`ifdef LED_PWM_EN
    if (off == duty_off(NUM_BANKS)) begin
      reg_hit = 1'b1;
      rd_mux  = duty;
    end
`endif
    if (off9[8]) reg_hit = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q <= '0;
      mode_q <= '0;
    end else if (bus.BUS_WE && !off9[8]) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (off == reg_off(k, OFF_DATA)) data_q[k] <= BUS_DATA;
        if (off == reg_off(k, OFF_MODE)) mode_q[k] <= BUS_DATA;
      end
    end
  end

`ifdef LED_PWM_EN
  logic [BANK_W-1:0] duty_q;

  always_ff @(posedge CLK) begin
    if (RESET)
      duty_q <= DUTY_RST;
    else if (bus.BUS_WE && !off9[8] && off == duty_off(NUM_BANKS))
      duty_q <= BUS_DATA;
  end

  assign duty = duty_q;
`else
  assign duty = DUTY_RST;
`endif

  // One-cycle read drive; back-to-back reads keep drv_en high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_q   <= '0;
      drv_en <= 1'b0;
    end else begin
      drv_en <= !bus.BUS_WE && reg_hit;
      if (!bus.BUS_WE && reg_hit) rd_q <= rd_mux;
    end
  end

  assign BUS_DATA = drv_en ? rd_q : 8'hzz;

  led_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .duty   (duty),
    .phase  (phase),
    .pwm_on (pwm_on)
  );

  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++)
      led_nxt[k] = data_q[k] & (~mode_q[k] | {BANK_W{phase}}) & {BANK_W{pwm_on}};
  end

  always_ff @(posedge CLK) begin
    if (RESET) LED_OUT <= '0;
    else       LED_OUT <= led_nxt;
  end

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Directed bench for led_bank_ctrl (NUM_BANKS=2, BLINK_DIV=4). A pullup on
// the data bus makes a released bus read as 8'hFF.
module tb_led_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_oe;
  logic [7:0]  tb_dout;
  wire  [7:0]  bus_data;
  logic [15:0] led;
  int          checks   = 0;
  int          failures = 0;

  localparam logic [7:0] REL = 8'hFF;

  led_bank_if bus_if ();

  assign bus_data = tb_oe ? tb_dout : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (bus_data[i]);
  end

  led_bank_ctrl #(
    .BASE_ADDR (8'hC0),
    .NUM_BANKS (2),
    .BLINK_DIV (4)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .bus      (bus_if),
    .BUS_DATA (bus_data),
    .LED_OUT  (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [7:0]  wdata;
    logic [15:0] exp_led;
    logic        chk_bus;
    logic [7:0]  exp_bus;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic we, input logic [7:0] d);
    bus_if.BUS_ADDR = a;
    bus_if.BUS_WE   = we;
    tb_oe           = we;
    tb_dout         = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev, v, other;
    logic       found;
    int         cnt;

    vecs[0]  = '{8'hC0, 1'b1, 8'hA5, 16'h0000, 1'b0, 8'h00};
    vecs[1]  = '{8'hC2, 1'b1, 8'h3C, 16'h00A5, 1'b0, 8'h00};
    vecs[2]  = '{8'h00, 1'b0, 8'h00, 16'h3CA5, 1'b1, REL};
    vecs[3]  = '{8'hC1, 1'b1, 8'h5A, 16'h3CA5, 1'b0, 8'h00};
    vecs[4]  = '{8'hC1, 1'b0, 8'h00, 16'h3CA5, 1'b1, 8'h5A};
    vecs[5]  = '{8'h00, 1'b0, 8'h00, 16'h3CA5, 1'b1, REL};
    vecs[6]  = '{8'hC0, 1'b0, 8'h00, 16'h3CA5, 1'b1, 8'hA5};
    vecs[7]  = '{8'hC2, 1'b0, 8'h00, 16'h3CA5, 1'b1, 8'h3C};
    vecs[8]  = '{8'hC3, 1'b0, 8'h00, 16'h3CA5, 1'b1, 8'h00};
    vecs[9]  = '{8'hC8, 1'b0, 8'h00, 16'h3CA5, 1'b1, REL};
    vecs[10] = '{8'hBF, 1'b0, 8'h00, 16'h3CA5, 1'b1, REL};
    vecs[11] = '{8'hC8, 1'b1, 8'h77, 16'h3CA5, 1'b0, 8'h00};
    vecs[12] = '{8'h00, 1'b0, 8'h00, 16'h3CA5, 1'b1, REL};
    vecs[13] = '{8'hC2, 1'b0, 8'h00, 16'h3CA5, 1'b1, 8'h3C};

    rst = 1'b1;
    drive(8'h00, 1'b0, 8'h00);
    repeat (3) cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_led", led, 16'h0000);
      chk("idle_bus", {8'h00, bus_data}, {8'h00, REL});
    end

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      cyc();
      chk($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      if (vecs[i].chk_bus)
        chk($sformatf("vec%0d_bus", i), {8'h00, bus_data}, {8'h00, vecs[i].exp_bus});
    end

    // Blink: DATA[0]=FF, MODE[0]=0F -> low byte alternates F0/FF every 4 cycles
    drive(8'h00, 1'b0, 8'h00); cyc();
    drive(8'hC0, 1'b1, 8'hFF); cyc();
    drive(8'hC1, 1'b1, 8'h0F); cyc();
    drive(8'h00, 1'b0, 8'h00); cyc(); cyc();
    prev  = led[7:0];
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (led[7:0] != prev) found = 1'b1;
    end
    chk("blink_edge_found", {15'd0, found}, 16'd1);
    v     = led[7:0];
    other = (v == 8'hF0) ? 8'hFF : 8'hF0;
    chk("blink_val", {15'd0, (v == 8'hF0 || v == 8'hFF)}, 16'd1);
    chk("blink_hi", {8'h00, led[15:8]}, 16'h003C);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("blink_k%0d", k), {8'h00, led[7:0]},
          {8'h00, (((k / 4) % 2) == 0) ? v : other});
    end

    // Reset during blink-on with a read of MODE[0] in flight
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (led[7:0] == 8'hFF) found = 1'b1;
      else cyc();
    end
    chk("blink_on_found", {15'd0, found}, 16'd1);
    drive(8'hC1, 1'b0, 8'h00); cyc();
    chk("inflight_bus", {8'h00, bus_data}, 16'h000F);
    rst = 1'b1;
    drive(8'hC0, 1'b0, 8'h00); cyc();
    chk("rst_led", led, 16'h0000);
    chk("rst_bus", {8'h00, bus_data}, {8'h00, REL});
    rst = 1'b0;
    drive(8'h00, 1'b0, 8'h00); cyc();
    for (int a = 0; a < 4; a++) begin
      drive(8'(8'hC0 + a), 1'b0, 8'h00); cyc();
      chk($sformatf("rb_%0d", a), {8'h00, bus_data}, 16'h0000);
    end
`ifdef LED_PWM_EN
    drive(8'hC4, 1'b0, 8'h00); cyc();
    chk("rb_duty", {8'h00, bus_data}, 16'h00FF);
`endif
    drive(8'h00, 1'b0, 8'h00); cyc();
    chk("post_rst_bus", {8'h00, bus_data}, {8'h00, REL});
    chk("post_rst_led", led, 16'h0000);

`ifdef LED_PWM_EN
    drive(8'hC0, 1'b1, 8'hFF); cyc();
    drive(8'hC4, 1'b1, 8'h40); cyc();
    drive(8'h00, 1'b0, 8'h00); cyc(); cyc();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin cyc(); cnt += int'(led[0]); end
    chk("pwm_40", 16'(cnt), 16'd64);
    drive(8'hC4, 1'b1, 8'h00); cyc();
    drive(8'h00, 1'b0, 8'h00); cyc(); cyc();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin cyc(); cnt += int'(led[0]); end
    chk("pwm_00", 16'(cnt), 16'd0);
    drive(8'hC4, 1'b1, 8'hFF); cyc();
    drive(8'h00, 1'b0, 8'h00); cyc(); cyc();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin cyc(); cnt += int'(led[0]); end
    chk("pwm_ff", 16'(cnt), 16'd256);
`else
    cnt = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
